// File: rtl/mem_req_ack_responder.sv
// mem_req_ack_responder: shared word memory answering imem/dmem req/ack ports with fixed per-port latency.
// Define MEM_RESP_ERR_EN to add imem_err_o/dmem_err_o for misaligned or out-of-range addresses.
module mem_req_ack_port #(
    parameter int PW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic [PW-1:0] pld_i,
    output logic          fire_o,
    output logic [PW-1:0] pld_o,
    output logic          ack_o
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] pld_q;
    logic          take;
    // IDLE and ACK both accept a new request; dropping req anywhere returns to IDLE
    always_comb begin
        take    = req_i && state_q != WAIT;
        fire_o  = req_i && (take ? LAT == 0 : cnt_q == 4'd1);
        state_d = !req_i ? IDLE : fire_o ? ACK : WAIT;
        cnt_d   = take ? 4'(LAT) : cnt_q - 4'd1;
        pld_o   = take ? pld_i : pld_q;
        ack_o   = state_q == ACK;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) pld_q <= pld_i;
        end
    end
endmodule

module mem_req_ack_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int IMEM_LAT   = 1,
    parameter int DMEM_LAT   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_ack_o,
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_ack_o
`ifdef MEM_RESP_ERR_EN
    ,
    output logic                  imem_err_o,
    output logic                  dmem_err_o
`endif
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  i_fire, d_fire, d_we, i_bad, d_bad, i_err_q, d_err_q;
    logic [ADDR_WIDTH-1:0] i_addr, d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DEPTH_LOG2-1:0] i_idx, d_idx;

    mem_req_ack_port #(.PW(ADDR_WIDTH), .LAT(IMEM_LAT)) u_imem (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(imem_req_i), .pld_i(imem_addr_i),
        .fire_o(i_fire), .pld_o(i_addr), .ack_o(imem_ack_o)
    );
    mem_req_ack_port #(.PW(1 + DATA_WIDTH + ADDR_WIDTH), .LAT(DMEM_LAT)) u_dmem (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(dmem_req_i),
        .pld_i({dmem_we_i, dmem_wdata_i, dmem_addr_i}),
        .fire_o(d_fire), .pld_o({d_we, d_wdata, d_addr}), .ack_o(dmem_ack_o)
    );

    assign i_idx = i_addr[DEPTH_LOG2+1:2];
    assign d_idx = d_addr[DEPTH_LOG2+1:2];
`ifdef MEM_RESP_ERR_EN
    assign i_bad      = |i_addr[1:0] || |i_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
    assign d_bad      = |d_addr[1:0] || |d_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];
    assign imem_err_o = imem_ack_o && i_err_q;
    assign dmem_err_o = dmem_ack_o && d_err_q;
`else
    logic unused_bits;
    assign unused_bits = ^{i_addr[1:0], i_addr[ADDR_WIDTH-1:DEPTH_LOG2+2],
                           d_addr[1:0], d_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], i_err_q, d_err_q};
    assign i_bad = 1'b0;
    assign d_bad = 1'b0;
`endif

    // reads sample mem before this edge's write, so a same-edge imem fetch sees old data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imem_rdata_o <= '0;
            dmem_rdata_o <= '0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            if (i_fire) begin
                imem_rdata_o <= i_bad ? '0 : mem[i_idx];
                i_err_q      <= i_bad;
            end
            if (d_fire) begin
                dmem_rdata_o <= d_bad ? '0 : d_we ? d_wdata : mem[d_idx];
                d_err_q      <= d_bad;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && d_fire && d_we && !d_bad) mem[d_idx] <= d_wdata;
    end
endmodule
